p2p_pattern_master: RTL

Master-side traffic generator and checker for the point-to-point link. It drives a deterministic word stream on `data_o` toward the slave end and checks each word returned on `data_i` against the bitwise inverse of the word sent. It sits behind the master-side point I/O slot and is the self-checking counterpart to the inverting responder on the slave end. It reports an error count and the index of the first mismatch.

---
 rtl/p2p_pkg.sv | 13 +
 rtl/p2p_delay_line.sv | 46 ++++
 rtl/p2p_pattern_master.sv | 132 +++++++++++++
 3 files changed

// File: rtl/p2p_pkg.sv
// Shared types and limits for the point-to-point pattern master.
package p2p_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } p2p_state_e;

   localparam int P2P_MAX_LATENCY = 8;

endpackage

// File: rtl/p2p_delay_line.sv
// Expected-value delay line: LATENCY+1 stages of {valid, word, index}.
module p2p_delay_line
   import p2p_pkg::*;
#(
   parameter int LATENCY = 1,
   parameter int WIDTH   = 16,
   parameter int IDX_W   = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic [IDX_W-1:0] push_idx_i,
   output logic             head_vld_o,
   output logic [WIDTH-1:0] head_data_o,
   output logic [IDX_W-1:0] head_idx_o,
   output logic             pending_o
);

   localparam int STAGES = LATENCY;

   logic [STAGES:0]            vld_pipe;
   logic [STAGES:0][WIDTH-1:0] data_pipe;
   logic [STAGES:0][IDX_W-1:0] idx_pipe;

   // Clear drops stale entries but still admits the word pushed on the same edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe  <= '0;
         data_pipe <= '0;
         idx_pipe  <= '0;
      end else begin
         vld_pipe  <= clear_i ? {{STAGES{1'b0}}, push_i} : {vld_pipe[STAGES-1:0], push_i};
         data_pipe <= {data_pipe[STAGES-1:0], push_data_i};
         idx_pipe  <= {idx_pipe[STAGES-1:0], push_idx_i};
      end
   end

   assign head_vld_o  = vld_pipe[STAGES];
   assign head_data_o = data_pipe[STAGES];
   assign head_idx_o  = idx_pipe[STAGES];
   // Anything left behind the head means more checks are still owed.
   assign pending_o   = |vld_pipe[STAGES-1:0];

endmodule

// File: rtl/p2p_pattern_master.sv
// Link traffic generator: streams seed+k on data_o and checks data_i against the
// inverted word LATENCY+1 edges later, counting mismatches and the first bad index.
module p2p_pattern_master
   import p2p_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int LATENCY = 1,
   parameter int COUNT_W = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic [COUNT_W-1:0] num_words,
   input  logic [WIDTH-1:0]   seed,
   output logic [WIDTH-1:0]   data_o,
   input  logic [WIDTH-1:0]   data_i,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] err_count,
   output logic               first_err_valid,
   output logic [COUNT_W-1:0] first_err_idx
);

   // Out-of-range latencies are pulled back into the supported 1..8 window.
   localparam int LAT = (LATENCY < 1) ? 1 :
                        (LATENCY > P2P_MAX_LATENCY) ? P2P_MAX_LATENCY : LATENCY;

   p2p_state_e         state_q;
   logic [COUNT_W-1:0] num_q, cnt_q, err_cnt_q, first_idx_q;
   logic [WIDTH-1:0]   data_q;
   logic               busy_q, done_q, fev_q;

   logic               accept, push, mismatch;
   logic [WIDTH-1:0]   word_d, push_word;
   logic [COUNT_W-1:0] cnt_d, err_cnt_d, push_idx;
   logic               head_vld, pending;
   logic [WIDTH-1:0]   head_data;
   logic [COUNT_W-1:0] head_idx;

   always_comb begin
      accept    = (state_q == ST_IDLE) && start;
      word_d    = data_q + WIDTH'(1);
      cnt_d     = cnt_q + COUNT_W'(1);
      push      = (accept && (num_words != '0)) || (state_q == ST_RUN);
      push_word = accept ? seed : word_d;
      push_idx  = accept ? '0 : cnt_q;
      mismatch  = head_vld && (data_i != head_data);
      err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + COUNT_W'(1);
   end

   p2p_delay_line #(
      .LATENCY (LAT),
      .WIDTH   (WIDTH),
      .IDX_W   (COUNT_W)
   ) u_dly (
      .clock       (clock),
      .reset_n     (reset_n),
      .clear_i     (accept),
      .push_i      (push),
      .push_data_i (~push_word),
      .push_idx_i  (push_idx),
      .head_vld_o  (head_vld),
      .head_data_o (head_data),
      .head_idx_o  (head_idx),
      .pending_o   (pending)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         num_q       <= '0;
         cnt_q       <= '0;
         data_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_cnt_q   <= '0;
         fev_q       <= 1'b0;
         first_idx_q <= '0;
      end else begin
         done_q <= 1'b0;
         // The head is never valid in IDLE, so the start-time clear below cannot collide.
         if (mismatch) begin
            err_cnt_q <= err_cnt_d;
            if (!fev_q) begin
               fev_q       <= 1'b1;
               first_idx_q <= head_idx;
            end
         end
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  num_q       <= num_words;
                  data_q      <= seed;
                  err_cnt_q   <= '0;
                  fev_q       <= 1'b0;
                  first_idx_q <= '0;
                  cnt_q       <= COUNT_W'(1);
                  if (num_words == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     busy_q  <= 1'b1;
                     state_q <= (num_words == COUNT_W'(1)) ? ST_DRAIN : ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               data_q <= word_d;
               cnt_q  <= cnt_d;
               if (cnt_d == num_q) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!pending) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign data_o          = data_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign err_count       = err_cnt_q;
   assign first_err_valid = fev_q;
   assign first_err_idx   = first_idx_q;

endmodule
